// File: rtl/sump3_lb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sump3_lb_arbiter
// Description : Two-requester round-robin arbiter in front of the sump3 core
//               local bus. Each accepted request produces a one-cycle chip
//               select / rd|wr strobe. Writes then complete. Reads wait for
//               lb_rd_rdy, or give up after rd_timeout WAIT cycles and return
//               32'hDEADBEEF with err set. Every output is registered.
// Ports       : clk_lb / reset         - clock, async active-high reset
//               reqN_valid/ctrl/wr/wr_d - request from requester N (N = 0,1)
//               reqN_done/rd_d/err      - completion pulse, read data, timeout
//               lb_cs_ctrl/lb_cs_data/lb_wr/lb_rd/lb_wr_d - core strobes, data
//               lb_rd_d / lb_rd_rdy     - read return from the core
//               busy                    - high whenever the FSM is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module sump3_lb_arbiter #(
    parameter int unsigned rd_timeout = 255
) (
    input  logic        clk_lb,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_ctrl,
    input  logic        req0_wr,
    input  logic [31:0] req0_wr_d,
    output logic        req0_done,
    output logic [31:0] req0_rd_d,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_ctrl,
    input  logic        req1_wr,
    input  logic [31:0] req1_wr_d,
    output logic        req1_done,
    output logic [31:0] req1_rd_d,
    output logic        req1_err,
    output logic        lb_cs_ctrl,
    output logic        lb_cs_data,
    output logic        lb_wr,
    output logic        lb_rd,
    output logic [31:0] lb_wr_d,
    input  logic [31:0] lb_rd_d,
    input  logic        lb_rd_rdy,
    output logic        busy
);

    localparam logic [1:0]  c_IDLE         = 2'd0;
    localparam logic [1:0]  c_ISSUE        = 2'd1;
    localparam logic [1:0]  c_WAIT         = 2'd2;
    localparam logic [1:0]  c_DONE         = 2'd3;
    localparam logic [8:0]  c_TIMEOUT      = 9'(rd_timeout);
    localparam logic [31:0] c_TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [1:0]  state_q, state_d;
    logic        grant_q, grant_d;
    logic        wr_q, wr_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cs_ctrl_q, cs_ctrl_d;
    logic        cs_data_q, cs_data_d;
    logic        lbwr_q, lbwr_d;
    logic        lbrd_q, lbrd_d;
    logic [31:0] wdat_q, wdat_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic        busy_q, busy_d;

    logic        w_any_req;
    logic        w_sel;
    logic        w_timeout_hit;
    logic        w_fin;
    logic        w_fin_err;
    logic [31:0] w_fin_data;

    assign w_any_req = req0_valid | req1_valid;

    // Round robin: on a tie the requester not served last wins; otherwise the
    // lone requester wins (w_sel = 1 only when req1 is the one asking).
    always_comb begin
        if (req0_valid && req1_valid) begin
            w_sel = ~last_grant_q;
        end else begin
            w_sel = req1_valid;
        end
    end

    // Counter enters WAIT at 0; the WAIT cycle in which it would step to
    // rd_timeout is the last one, so WAIT lasts exactly rd_timeout cycles.
    assign w_timeout_hit = (({1'b0, cnt_q} + 9'd1) == c_TIMEOUT);

    // Transaction finishes this cycle (next state is DONE). Read data beats a
    // coincident timeout because lb_rd_rdy is tested first.
    assign w_fin      = ((state_q == c_ISSUE) && (wr_q || lb_rd_rdy)) ||
                        ((state_q == c_WAIT)  && (lb_rd_rdy || w_timeout_hit));
    assign w_fin_err  = ~wr_q & ~lb_rd_rdy;
    assign w_fin_data = lb_rd_rdy ? lb_rd_d : c_TIMEOUT_DATA;

    // State register
    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_any_req) state_d = c_ISSUE;
            c_ISSUE: state_d = (wr_q || lb_rd_rdy) ? c_DONE : c_WAIT;
            c_WAIT:  if (lb_rd_rdy || w_timeout_hit) state_d = c_DONE;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output / datapath next-values; strobes are loaded on the IDLE->ISSUE
    // edge so they are high for exactly the ISSUE cycle.
    always_comb begin
        grant_d      = grant_q;
        wr_d         = wr_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        cs_ctrl_d    = 1'b0;
        cs_data_d    = 1'b0;
        lbwr_d       = 1'b0;
        lbrd_d       = 1'b0;
        wdat_d       = wdat_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        err0_d       = err0_q;
        err1_d       = err1_q;
        busy_d       = (state_d != c_IDLE);

        case (state_q)
            c_IDLE: begin
                if (w_any_req) begin
                    grant_d      = w_sel;
                    last_grant_d = w_sel;
                    wr_d         = w_sel ? req1_wr   : req0_wr;
                    cs_ctrl_d    = w_sel ? req1_ctrl : req0_ctrl;
                    cs_data_d    = ~cs_ctrl_d;
                    lbwr_d       = wr_d;
                    lbrd_d       = ~wr_d;
                    wdat_d       = w_sel ? req1_wr_d : req0_wr_d;
                end
            end
            c_ISSUE: cnt_d = 8'd0;
            c_WAIT:  cnt_d = cnt_q + 8'd1;
            default: ;
        endcase

        if (w_fin) begin
            if (grant_q) begin
                done1_d = 1'b1;
                err1_d  = w_fin_err;
                if (!wr_q) rd1_d = w_fin_data;
            end else begin
                done0_d = 1'b1;
                err0_d  = w_fin_err;
                if (!wr_q) rd0_d = w_fin_data;
            end
        end
    end

    // Output / datapath registers
    always_ff @(posedge clk_lb or posedge reset) begin
        if (reset) begin
            grant_q      <= 1'b0;
            wr_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 8'd0;
            cs_ctrl_q    <= 1'b0;
            cs_data_q    <= 1'b0;
            lbwr_q       <= 1'b0;
            lbrd_q       <= 1'b0;
            wdat_q       <= 32'd0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rd0_q        <= 32'd0;
            rd1_q        <= 32'd0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            wr_q         <= wr_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            cs_ctrl_q    <= cs_ctrl_d;
            cs_data_q    <= cs_data_d;
            lbwr_q       <= lbwr_d;
            lbrd_q       <= lbrd_d;
            wdat_q       <= wdat_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            busy_q       <= busy_d;
        end
    end

    assign lb_cs_ctrl = cs_ctrl_q;
    assign lb_cs_data = cs_data_q;
    assign lb_wr      = lbwr_q;
    assign lb_rd      = lbrd_q;
    assign lb_wr_d    = wdat_q;
    assign req0_done  = done0_q;
    assign req1_done  = done1_q;
    assign req0_rd_d  = rd0_q;
    assign req1_rd_d  = rd1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_sump3_lb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sump3_lb_arbiter
// Description : Self-checking bench for sump3_lb_arbiter. Requests are queued
//               per requester as whole transactions; a transaction-level model
//               (round-robin pick, latency = 1 or 1+min(delay,timeout)) gives
//               the expected cycle-by-cycle outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sump3_lb_arbiter;

    localparam int c_T = 8;

    logic        clk_lb = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ctrl, req0_wr;
    logic [31:0] req0_wr_d;
    logic        req0_done, req0_err;
    logic [31:0] req0_rd_d;
    logic        req1_valid, req1_ctrl, req1_wr;
    logic [31:0] req1_wr_d;
    logic        req1_done, req1_err;
    logic [31:0] req1_rd_d;
    logic        lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd;
    logic [31:0] lb_wr_d;
    logic [31:0] lb_rd_d;
    logic        lb_rd_rdy;
    logic        busy;

    sump3_lb_arbiter #(.rd_timeout(c_T)) u_dut (
        .clk_lb     (clk_lb),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ctrl  (req0_ctrl),
        .req0_wr    (req0_wr),
        .req0_wr_d  (req0_wr_d),
        .req0_done  (req0_done),
        .req0_rd_d  (req0_rd_d),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_ctrl  (req1_ctrl),
        .req1_wr    (req1_wr),
        .req1_wr_d  (req1_wr_d),
        .req1_done  (req1_done),
        .req1_rd_d  (req1_rd_d),
        .req1_err   (req1_err),
        .lb_cs_ctrl (lb_cs_ctrl),
        .lb_cs_data (lb_cs_data),
        .lb_wr      (lb_wr),
        .lb_rd      (lb_rd),
        .lb_wr_d    (lb_wr_d),
        .lb_rd_d    (lb_rd_d),
        .lb_rd_rdy  (lb_rd_rdy),
        .busy       (busy)
    );

    always #5 clk_lb = ~clk_lb;

    typedef struct {
        logic        ctrl;
        logic        wr;
        logic [31:0] wd;
        int          d;     // cycles after the strobe at which rdy is driven
        logic [31:0] rv;    // data the core returns with rdy
    } op_t;

    op_t q0[$];
    op_t q1[$];

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          last_strobe;
    logic        m_last;
    logic [31:0] m_rd [2];
    logic        m_err [2];
    logic [31:0] m_wd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_lb);
        #1;
        cyc++;
    endtask

    function automatic op_t mk_op(input logic c, input logic w, input logic [31:0] wd,
                                  input int d, input logic [31:0] rv);
        op_t o;
        o.ctrl = c; o.wr = w; o.wd = wd; o.d = d; o.rv = rv;
        return o;
    endfunction

    function automatic op_t rand_op();
        return mk_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     int'($urandom_range(0, c_T + 2)), $urandom);
    endfunction

    task automatic present(input int n);
        if (n == 0) begin
            if (q0.size() > 0) begin
                req0_valid = 1'b1; req0_ctrl = q0[0].ctrl; req0_wr = q0[0].wr; req0_wr_d = q0[0].wd;
            end else begin
                req0_valid = 1'b0;
            end
        end else begin
            if (q1.size() > 0) begin
                req1_valid = 1'b1; req1_ctrl = q1[0].ctrl; req1_wr = q1[0].wr; req1_wr_d = q1[0].wd;
            end else begin
                req1_valid = 1'b0;
            end
        end
    endtask

    // Expected state of all outputs while no transaction is in flight.
    task automatic check_quiet(input string tag);
        check_eq({tag, ".busy"},   32'(busy), 0);
        check_eq({tag, ".strobe"}, 32'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}), 0);
        check_eq({tag, ".done"},   32'({req1_done, req0_done}), 0);
        check_eq({tag, ".wr_d"},   lb_wr_d, m_wd);
        check_eq({tag, ".rd0"},    req0_rd_d, m_rd[0]);
        check_eq({tag, ".rd1"},    req1_rd_d, m_rd[1]);
        check_eq({tag, ".err0"},   32'(req0_err), 32'(m_err[0]));
        check_eq({tag, ".err1"},   32'(req1_err), 32'(m_err[1]));
    endtask

    task automatic model_reset();
        m_last = 1'b1; m_rd[0] = '0; m_rd[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        m_wd = '0; last_strobe = -100;
        q0.delete(); q1.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; lb_rd_rdy = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        model_reset();
        check_quiet("reset");
    endtask

    task automatic idle_gap(input int n);
        for (int k = 0; k < n; k++) begin
            lb_rd_rdy = 1'($urandom_range(0, 1));
            lb_rd_d   = $urandom;
            check_quiet("gap");
            tick();
        end
        lb_rd_rdy = 1'b0;
    endtask

    // Serve both queues to empty. drop >= 0 forces where a requester's last
    // valid is released (offset from its strobe cycle); <0 picks at random.
    task automatic run_queues(input int drop);
        op_t o;
        int  g, len, drop_at, oth;
        present(0);
        present(1);
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
            else                                g = (q1.size() > 0) ? 1 : 0;
            oth    = 1 - g;
            m_last = (g == 1);
            o      = (g == 1) ? q1[0] : q0[0];
            len    = o.wr ? 1 : 1 + ((o.d < c_T) ? o.d : c_T);
            if (((g == 1) ? q1.size() : q0.size()) == 1)
                drop_at = (drop >= 0) ? drop : int'($urandom_range(0, len));
            else
                drop_at = -1;
            tick();
            for (int j = 0; j <= len; j++) begin
                lb_rd_rdy = o.wr ? 1'($urandom_range(0, 1)) : (j == o.d);
                lb_rd_d   = (!o.wr && j == o.d) ? o.rv : $urandom;
                if (j == drop_at) begin
                    if (g == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
                end
                if (j == 0) begin
                    check_eq("strobe", 32'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}),
                             32'({o.ctrl, !o.ctrl, o.wr, !o.wr}));
                    check_eq("lb_wr_d", lb_wr_d, o.wd);
                    m_wd = o.wd;
                    check_eq("spacing", 32'((cyc - last_strobe) >= 3), 1);
                    last_strobe = cyc;
                end else begin
                    check_eq("strobe_off", 32'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}), 0);
                    check_eq("wr_d_hold", lb_wr_d, m_wd);
                end
                if (j == len) begin
                    if (!o.wr) begin
                        m_rd[g]  = (o.d <= c_T) ? o.rv : 32'hDEAD_BEEF;
                        m_err[g] = (o.d > c_T);
                    end else begin
                        m_err[g] = 1'b0;
                    end
                    check_eq("err_granted", 32'((g == 1) ? req1_err : req0_err), 32'(m_err[g]));
                    if (g == 1) void'(q1.pop_front()); else void'(q0.pop_front());
                    present(g);
                end
                check_eq("busy", 32'(busy), 1);
                check_eq("done", 32'({req1_done, req0_done}),
                         (j == len) ? ((g == 1) ? 32'd2 : 32'd1) : 32'd0);
                check_eq("rd0", req0_rd_d, m_rd[0]);
                check_eq("rd1", req1_rd_d, m_rd[1]);
                check_eq("err_other", 32'((oth == 1) ? req1_err : req0_err), 32'(m_err[oth]));
                tick();
            end
            // Late rdy for a timed-out read lands here, in IDLE, and is ignored.
            lb_rd_rdy = !o.wr && (o.d == len + 1);
            lb_rd_d   = $urandom;
            check_quiet("idle");
        end
        lb_rd_rdy = 1'b0;
    endtask

    initial begin
        req0_ctrl = 1'b0; req0_wr = 1'b0; req0_wr_d = '0;
        req1_ctrl = 1'b0; req1_wr = 1'b0; req1_wr_d = '0;
        lb_rd_d = '0;
        do_reset();

        // req0 control write of 1: strobe +1, done +2, idle +3
        q0.push_back(mk_op(1'b1, 1'b1, 32'h0000_0001, 0, 32'h0));
        run_queues(-1);

        // req1 data read, core answers 3 cycles after the strobe
        q1.push_back(mk_op(1'b0, 1'b0, 32'h0, 3, 32'h1234_5678));
        run_queues(-1);
        idle_gap(2);

        // Both valid from reset, 4 writes each: strict alternation from req0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            q0.push_back(mk_op(1'b1, 1'b1, 32'h100 + k, 0, 32'h0));
            q1.push_back(mk_op(1'b0, 1'b1, 32'h200 + k, 0, 32'h0));
        end
        run_queues(-1);

        // Timeout boundaries: never, coincident with last WAIT cycle, one
        // before, one after, and same-cycle response.
        q0.push_back(mk_op(1'b0, 1'b0, 32'h0, 1000, 32'h0));
        q0.push_back(mk_op(1'b1, 1'b0, 32'h0, c_T,     32'hCAFE_0008));
        q0.push_back(mk_op(1'b0, 1'b0, 32'h0, c_T - 1, 32'hCAFE_0007));
        q1.push_back(mk_op(1'b0, 1'b0, 32'h0, c_T + 1, 32'hCAFE_0009));
        q1.push_back(mk_op(1'b1, 1'b0, 32'h0, 0,       32'hCAFE_0000));
        run_queues(-1);

        // Valid dropped right after acceptance
        q0.push_back(mk_op(1'b0, 1'b1, 32'h5555_AAAA, 0, 32'h0));
        run_queues(0);
        q0.push_back(mk_op(1'b1, 1'b0, 32'h0, 2, 32'h7777_1111));
        run_queues(0);

        // Randomized traffic
        for (int r = 0; r < 60; r++) begin
            int n0, n1;
            n0 = int'($urandom_range(0, 3));
            n1 = int'($urandom_range(0, 3));
            for (int k = 0; k < n0; k++) q0.push_back(rand_op());
            for (int k = 0; k < n1; k++) q1.push_back(rand_op());
            run_queues(-1);
            idle_gap(int'($urandom_range(0, 3)));
        end

        // Reset asserted mid-read, then stray rdy, then a tie goes to req0
        q0.push_back(mk_op(1'b0, 1'b0, 32'hA5A5_0000, 1000, 32'h0));
        present(0);
        tick();
        check_eq("rst_pre_strobe", 32'({lb_cs_ctrl, lb_cs_data, lb_wr, lb_rd}), 32'b0101);
        repeat (3) tick();
        check_eq("rst_pre_busy", 32'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_quiet("async_rst");
        req0_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lb_rd_rdy = 1'b1;
            lb_rd_d   = $urandom;
            check_quiet("post_rst");
            tick();
        end
        lb_rd_rdy = 1'b0;
        check_quiet("post_rst_end");
        q0.push_back(mk_op(1'b0, 1'b1, 32'hAAAA_0000, 0, 32'h0));
        q1.push_back(mk_op(1'b1, 1'b1, 32'hBBBB_0000, 0, 32'h0));
        run_queues(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
